fec_lock_ctrl: RTL
==================

Name: fec_lock_ctrl

Overview:
- Parametrised, multi-lane FEC frame-lock and bit-slip controller for the KR FEC decoder.
- Replaces the single-lane fixed-threshold lock logic that sits between the CRC-syndrome compare stage and the bit-slip stage.
- Per lane it hunts for the 2112-bit FEC frame boundary by issuing slips, declares and drops lock using programmable good/bad block thresholds, flags lock timeout, and keeps a saturating slip statistic.
- One instance serves LANES independent channels.

Parameters:
- LANES, 4: number of independent lanes.
- GOOD_TO_LOCK, 4: consecutive good blocks (range 1..255) required to declare lock.
- BAD_TO_UNLOCK, 8: consecutive bad blocks (range 1..255) while locked that drop lock.
- SLIP_SETTLE, 2: syndrome events (range 0..15) ignored after each slip.
- MAX_SLIPS, 2112: slips without lock before a timeout flag is raised.
- STAT_W, 16: width of the per-lane saturating slip statistic.

Ports:
- CLK  in  1  Decoder clock.
- RST_N  in  1  Reset, asynchronous, active-low.
- CSR_FEC_EN  in  LANES  Per-lane enable. Low holds the lane in DISABLED.
- CSR_STAT_CLR  in  LANES  Per-lane synchronous clear of STAT_SLIP_CNT.
- SYNDR_VAL  in  LANES  One-cycle strobe: the syndrome of one FEC block is valid.
- CRC_FAIL  in  LANES  Qualified by SYNDR_VAL. 1 = nonzero syndrome (bad block).
- SLIP  out  LANES  One-cycle pulse requesting a 1-bit slip.
- FEC_LOCK  out  LANES  Level. Lane is frame-locked.
- LOCK_TO  out  LANES  One-cycle pulse: MAX_SLIPS slips were made without achieving lock.
- LOSS_LOCK  out  LANES  One-cycle pulse on the LOCKED->SLIP_WAIT transition.
- STAT_SLIP_CNT  out  LANES*STAT_W  Per-lane saturating slip count. Lane n occupies bits [n*STAT_W +: STAT_W].

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0, all counters 0, every lane in DISABLED. Reset takes effect immediately even mid-hunt; a SLIP pulse in flight is cancelled.
- Lanes are fully independent. There is no cross-lane interaction.
- All outputs are registered. A response appears the cycle after the qualifying SYNDR_VAL.
- CRC_FAIL is ignored when SYNDR_VAL is 0.
- FSM per lane, with states DISABLED, HUNT, SLIP_WAIT, LOCKED:
  - DISABLED: FEC_LOCK=0, no slips. When CSR_FEC_EN=1 -> HUNT with good_cnt=0 and try_cnt=0.
  - HUNT, good block: good_cnt++. When good_cnt reaches GOOD_TO_LOCK -> LOCKED; FEC_LOCK=1 next cycle; try_cnt=0; bad_cnt=0.
  - HUNT, bad block: SLIP pulse next cycle; good_cnt=0; try_cnt++; STAT_SLIP_CNT++ (saturates at 2^STAT_W-1); -> SLIP_WAIT with settle_cnt=0.
  - HUNT, timeout: if the bad block makes try_cnt equal MAX_SLIPS, LOCK_TO pulses in the same cycle as SLIP. try_cnt wraps to 0 and hunting continues.
  - SLIP_WAIT: each SYNDR_VAL increments settle_cnt; CRC_FAIL is disregarded. When settle_cnt reaches SLIP_SETTLE -> HUNT. If SLIP_SETTLE=0, go to HUNT the cycle after entry.
  - LOCKED, good block: bad_cnt=0.
  - LOCKED, bad block: bad_cnt++. When bad_cnt reaches BAD_TO_UNLOCK: FEC_LOCK=0, LOSS_LOCK pulse, SLIP pulse, STAT_SLIP_CNT++, good_cnt=0, try_cnt=1 -> SLIP_WAIT. All of these take effect in the same cycle.
- CSR_FEC_EN=0 in any state -> DISABLED on the next edge. It has priority over a simultaneous SYNDR_VAL; no SLIP, LOCK_TO or LOSS_LOCK is issued.
- CSR_STAT_CLR coincident with a slip: the counter loads 1. The clear wins, then the slip is counted.
- SLIP is never asserted on two consecutive cycles.
- Counter widths: good_cnt and bad_cnt are 8 bits, settle_cnt is 4 bits, try_cnt is $clog2(MAX_SLIPS+1) bits.
- Illegal parameter values are caught by elaboration-time checks: GOOD_TO_LOCK=0, BAD_TO_UNLOCK=0, MAX_SLIPS<2, STAT_W<1.

Decomposition:
- Package fec_lock_pkg holds:
  - state enum (DISABLED, HUNT, SLIP_WAIT, LOCKED);
  - counter-width constants;
  - default threshold constants shared with the CSR map.
- Sub-module fec_lock_lane contains the single-lane FSM, counters and statistic. The top generates LANES copies and packs the vectors.

Test Plan:
1. Reset, CSR_FEC_EN=4'hF, lane0 gets 4 good SYNDR_VAL -> FEC_LOCK[0] rises the cycle after the 4th strobe; SLIP stays 0 and STAT_SLIP_CNT lane0=0.
2. Lane1 pattern bad, then 2 ignored strobes, then 4 good (SLIP_SETTLE=2) -> exactly one SLIP[1] pulse, FEC_LOCK[1]=1, STAT lane1=1. Bad strobes applied during SLIP_WAIT produce no extra slip.
3. Lane2 locked, then 7 bad, 1 good, 8 bad -> lock is held through the first 7 bad. On the 8th consecutive bad, FEC_LOCK[2] falls and LOSS_LOCK[2] and SLIP[2] pulse together.
4. MAX_SLIPS=4, lane3 all-bad stream -> LOCK_TO[3] coincides with the 4th and 8th SLIP; STAT lane3 reads 8. With STAT_W=3 the statistic saturates at 7.
5. Assert RST_N low mid-hunt, and separately drop CSR_FEC_EN on the same cycle as a bad SYNDR_VAL -> outputs clear immediately on reset; no SLIP is issued on enable drop; after re-enable the lane restarts in HUNT with counters 0.
6. CSR_STAT_CLR on the same cycle as a slip -> statistic reads 1 the next cycle.

Source files
------------

// File: rtl/fec_lock_pkg.sv
// Shared types and constants for the multi-lane FEC frame-lock controller.
// Default thresholds here match the reset values of the CSR map.
package fec_lock_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED  = 2'd0,
    ST_HUNT      = 2'd1,
    ST_SLIP_WAIT = 2'd2,
    ST_LOCKED    = 2'd3
  } lane_state_e;

  localparam int GOOD_CNT_W   = 8;
  localparam int BAD_CNT_W    = 8;
  localparam int SETTLE_CNT_W = 4;

  localparam int DEF_LANES         = 4;
  localparam int DEF_GOOD_TO_LOCK  = 4;
  localparam int DEF_BAD_TO_UNLOCK = 8;
  localparam int DEF_SLIP_SETTLE   = 2;
  localparam int DEF_MAX_SLIPS     = 2112;
  localparam int DEF_STAT_W        = 16;

  // try_cnt must hold MAX_SLIPS itself for the timeout compare.
  function automatic int try_cnt_w(input int max_slips);
    return $clog2(max_slips + 1);
  endfunction

endpackage

// File: rtl/fec_lock_lane.sv
// Single-lane frame-boundary hunt FSM: slip on bad blocks, lock on a run of
// good blocks, drop lock on a run of bad blocks, plus a saturating slip count.
module fec_lock_lane
  import fec_lock_pkg::*;
#(
  parameter int GOOD_TO_LOCK  = DEF_GOOD_TO_LOCK,
  parameter int BAD_TO_UNLOCK = DEF_BAD_TO_UNLOCK,
  parameter int SLIP_SETTLE   = DEF_SLIP_SETTLE,
  parameter int MAX_SLIPS     = DEF_MAX_SLIPS,
  parameter int STAT_W        = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_stat_clr,
  input  logic              i_syndr_val,
  input  logic              i_crc_fail,
  output logic              o_slip,
  output logic              o_fec_lock,
  output logic              o_lock_to,
  output logic              o_loss_lock,
  output logic [STAT_W-1:0] o_stat
);

  localparam int TRY_W = try_cnt_w(MAX_SLIPS);

  localparam logic [GOOD_CNT_W-1:0]   GOOD_TH   = GOOD_CNT_W'(GOOD_TO_LOCK);
  localparam logic [BAD_CNT_W-1:0]    BAD_TH    = BAD_CNT_W'(BAD_TO_UNLOCK);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_TH = SETTLE_CNT_W'(SLIP_SETTLE);
  localparam logic [TRY_W-1:0]        TRY_MAX   = TRY_W'(MAX_SLIPS);

  lane_state_e               r_state;
  logic [GOOD_CNT_W-1:0]     r_good;
  logic [BAD_CNT_W-1:0]      r_bad;
  logic [SETTLE_CNT_W-1:0]   r_settle;
  logic [TRY_W-1:0]          r_try;
  logic [STAT_W-1:0]         r_stat;
  logic                      r_slip;
  logic                      r_lock;
  logic                      r_lock_to;
  logic                      r_loss;

  logic                      w_good;
  logic                      w_bad;
  logic [GOOD_CNT_W-1:0]     w_good_inc;
  logic [BAD_CNT_W-1:0]      w_bad_inc;
  logic [SETTLE_CNT_W-1:0]   w_settle_inc;
  logic [TRY_W-1:0]          w_try_inc;
  logic                      w_unlock;
  logic                      w_slip_evt;

  assign w_good       = i_syndr_val & ~i_crc_fail;
  assign w_bad        = i_syndr_val &  i_crc_fail;
  assign w_good_inc   = r_good + GOOD_CNT_W'(1);
  assign w_bad_inc    = r_bad + BAD_CNT_W'(1);
  assign w_settle_inc = r_settle + SETTLE_CNT_W'(1);
  assign w_try_inc    = r_try + TRY_W'(1);
  assign w_unlock     = (r_state == ST_LOCKED) && w_bad && (w_bad_inc == BAD_TH);

  // A disable on the same edge suppresses the slip and its statistic.
  assign w_slip_evt   = i_en && ((r_state == ST_HUNT && w_bad) || w_unlock);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_DISABLED;
      r_good    <= '0;
      r_bad     <= '0;
      r_settle  <= '0;
      r_try     <= '0;
      r_slip    <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_to <= 1'b0;
      r_loss    <= 1'b0;
    end else begin
      r_slip    <= 1'b0;
      r_lock_to <= 1'b0;
      r_loss    <= 1'b0;
      if (!i_en) begin
        r_state  <= ST_DISABLED;
        r_lock   <= 1'b0;
        r_good   <= '0;
        r_bad    <= '0;
        r_settle <= '0;
        r_try    <= '0;
      end else begin
        case (r_state)
          ST_DISABLED: begin
            r_state <= ST_HUNT;
            r_good  <= '0;
            r_try   <= '0;
          end
          ST_HUNT: begin
            if (w_good) begin
              r_good <= w_good_inc;
              if (w_good_inc == GOOD_TH) begin
                r_state <= ST_LOCKED;
                r_lock  <= 1'b1;
                r_try   <= '0;
                r_bad   <= '0;
              end
            end else if (w_bad) begin
              r_slip   <= 1'b1;
              r_good   <= '0;
              r_settle <= '0;
              r_state  <= ST_SLIP_WAIT;
              if (w_try_inc == TRY_MAX) begin
                r_lock_to <= 1'b1;
                r_try     <= '0;
              end else begin
                r_try <= w_try_inc;
              end
            end
          end
          ST_SLIP_WAIT: begin
            // Syndromes here describe pre-slip alignment; only count them.
            if (SLIP_SETTLE == 0) begin
              r_state <= ST_HUNT;
            end else if (i_syndr_val) begin
              r_settle <= w_settle_inc;
              if (w_settle_inc == SETTLE_TH) r_state <= ST_HUNT;
            end
          end
          ST_LOCKED: begin
            if (w_good) begin
              r_bad <= '0;
            end else if (w_bad) begin
              r_bad <= w_bad_inc;
              if (w_unlock) begin
                r_lock   <= 1'b0;
                r_loss   <= 1'b1;
                r_slip   <= 1'b1;
                r_good   <= '0;
                r_try    <= TRY_W'(1);
                r_settle <= '0;
                r_state  <= ST_SLIP_WAIT;
              end
            end
          end
          default: r_state <= ST_DISABLED;
        endcase
      end
    end
  end

  // Clear has priority, then the coincident slip is counted on top of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else if (i_stat_clr) begin
      r_stat <= w_slip_evt ? STAT_W'(1) : '0;
    end else if (w_slip_evt && (r_stat != '1)) begin
      r_stat <= r_stat + STAT_W'(1);
    end
  end

  assign o_slip      = r_slip;
  assign o_fec_lock  = r_lock;
  assign o_lock_to   = r_lock_to;
  assign o_loss_lock = r_loss;
  assign o_stat      = r_stat;

endmodule

// File: rtl/fec_lock_ctrl.sv
// Multi-lane FEC frame-lock / bit-slip controller: LANES independent copies
// of the per-lane FSM with the per-lane outputs packed into flat vectors.
module fec_lock_ctrl
  import fec_lock_pkg::*;
#(
  parameter int LANES         = DEF_LANES,
  parameter int GOOD_TO_LOCK  = DEF_GOOD_TO_LOCK,
  parameter int BAD_TO_UNLOCK = DEF_BAD_TO_UNLOCK,
  parameter int SLIP_SETTLE   = DEF_SLIP_SETTLE,
  parameter int MAX_SLIPS     = DEF_MAX_SLIPS,
  parameter int STAT_W        = DEF_STAT_W
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [LANES-1:0]        CSR_FEC_EN,
  input  logic [LANES-1:0]        CSR_STAT_CLR,
  input  logic [LANES-1:0]        SYNDR_VAL,
  input  logic [LANES-1:0]        CRC_FAIL,
  output logic [LANES-1:0]        SLIP,
  output logic [LANES-1:0]        FEC_LOCK,
  output logic [LANES-1:0]        LOCK_TO,
  output logic [LANES-1:0]        LOSS_LOCK,
  output logic [LANES*STAT_W-1:0] STAT_SLIP_CNT
);

  if (LANES < 1) begin : g_chk_lanes
    $error("fec_lock_ctrl: LANES must be >= 1");
  end
  if (GOOD_TO_LOCK < 1 || GOOD_TO_LOCK > 255) begin : g_chk_good
    $error("fec_lock_ctrl: GOOD_TO_LOCK must be 1..255");
  end
  if (BAD_TO_UNLOCK < 1 || BAD_TO_UNLOCK > 255) begin : g_chk_bad
    $error("fec_lock_ctrl: BAD_TO_UNLOCK must be 1..255");
  end
  if (SLIP_SETTLE < 0 || SLIP_SETTLE > 15) begin : g_chk_settle
    $error("fec_lock_ctrl: SLIP_SETTLE must be 0..15");
  end
  if (MAX_SLIPS < 2) begin : g_chk_slips
    $error("fec_lock_ctrl: MAX_SLIPS must be >= 2");
  end
  if (STAT_W < 1) begin : g_chk_stat
    $error("fec_lock_ctrl: STAT_W must be >= 1");
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fec_lock_lane #(
      .GOOD_TO_LOCK (GOOD_TO_LOCK),
      .BAD_TO_UNLOCK(BAD_TO_UNLOCK),
      .SLIP_SETTLE  (SLIP_SETTLE),
      .MAX_SLIPS    (MAX_SLIPS),
      .STAT_W       (STAT_W)
    ) u_lane (
      .clk        (CLK),
      .rst_n      (RST_N),
      .i_en       (CSR_FEC_EN[g]),
      .i_stat_clr (CSR_STAT_CLR[g]),
      .i_syndr_val(SYNDR_VAL[g]),
      .i_crc_fail (CRC_FAIL[g]),
      .o_slip     (SLIP[g]),
      .o_fec_lock (FEC_LOCK[g]),
      .o_lock_to  (LOCK_TO[g]),
      .o_loss_lock(LOSS_LOCK[g]),
      .o_stat     (STAT_SLIP_CNT[g*STAT_W +: STAT_W])
    );
  end

endmodule
